// File: rtl/proc_sequencer.sv
// proc_sequencer: run controller that sits upstream of instruction fetch.
// It sequences IDLE -> CLEAR -> RUN/STALL -> DONE/FAULT and counts
// cycles and instructions for the current or last run.
module proc_sequencer #(
  parameter int unsigned CLEAR_CYCLES = 1,
  parameter logic [15:0] MAX_CYCLES   = 16'd4096
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_in,
  input  logic        stall_in,
  input  logic        ack,
  output logic [1:0]  state_ctrl,
  output logic        reset_ctrl,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CLR_W  = 4;
  localparam int unsigned CTRL_W = 2;

  localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [CTRL_W-1:0] CTRL_RUN  = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_HOLD = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_HALT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STALL,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state, state_next;
  logic [CLR_W-1:0]   clr_cnt, clr_cnt_next;
  logic [CNT_W-1:0]   cycle_next, instr_next;
  logic               wd_hit;
  logic [CTRL_W-1:0]  state_ctrl_next;
  logic               reset_ctrl_next;
  logic               busy_next;
  logic               done_next;
  logic               fault_next;

  // Saturating increment; counters must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    cycle_next   = cycle_count;
    instr_next   = instr_count;
    wd_hit       = (MAX_CYCLES != '0) && (cycle_count == MAX_CYCLES - CNT_W'(1));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next   = S_CLEAR;
          clr_cnt_next = CLR_LOAD;
          cycle_next   = '0;
          instr_next   = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == '0) state_next = S_RUN;
        else               clr_cnt_next = clr_cnt - CLR_W'(1);
      end
      S_RUN: begin
        cycle_next = sat_inc(cycle_count);
        if (halt_in)       state_next = S_DONE;
        else if (wd_hit)   state_next = S_FAULT;
        else if (stall_in) state_next = S_STALL;
        else               instr_next = sat_inc(instr_count);
      end
      S_STALL: begin
        // halt_in is not a valid decode while stalled, so it is ignored here
        cycle_next = sat_inc(cycle_count);
        if (wd_hit)         state_next = S_FAULT;
        else if (!stall_in) state_next = S_RUN;
      end
      S_DONE, S_FAULT: begin
        if (start) begin
          state_next   = S_CLEAR;
          clr_cnt_next = CLR_LOAD;
          cycle_next   = '0;
          instr_next   = '0;
        end else if (ack) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    state_ctrl_next = CTRL_HOLD;
    reset_ctrl_next = 1'b0;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    fault_next      = 1'b0;
    case (state_next)
      S_CLEAR: begin
        reset_ctrl_next = 1'b1;
        busy_next       = 1'b1;
      end
      S_RUN: begin
        state_ctrl_next = CTRL_RUN;
        busy_next       = 1'b1;
      end
      S_STALL: busy_next = 1'b1;
      S_DONE: begin
        state_ctrl_next = CTRL_HALT;
        done_next       = 1'b1;
      end
      S_FAULT: begin
        state_ctrl_next = CTRL_HALT;
        fault_next      = 1'b1;
      end
      default: state_ctrl_next = CTRL_HOLD;
    endcase
  end

  // State, counters and registered outputs; synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      state_ctrl  <= CTRL_HOLD;
      reset_ctrl  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      clr_cnt     <= clr_cnt_next;
      cycle_count <= cycle_next;
      instr_count <= instr_next;
      state_ctrl  <= state_ctrl_next;
      reset_ctrl  <= reset_ctrl_next;
      busy        <= busy_next;
      done        <= done_next;
      fault       <= fault_next;
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: one default instance and one with
// CLEAR_CYCLES=3, MAX_CYCLES=10 sharing the same stimulus.
module tb_proc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        ack = 1'b0;

  logic [1:0]  a_state_ctrl, b_state_ctrl;
  logic        a_reset_ctrl, b_reset_ctrl;
  logic        a_busy, b_busy;
  logic        a_done, b_done;
  logic        a_fault, b_fault;
  logic [15:0] a_cycle, b_cycle;
  logic [15:0] a_instr, b_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_sequencer u_dut_a (
    .CLK(clk), .reset(reset), .start(start), .halt_in(halt_in),
    .stall_in(stall_in), .ack(ack),
    .state_ctrl(a_state_ctrl), .reset_ctrl(a_reset_ctrl), .busy(a_busy),
    .done(a_done), .fault(a_fault), .cycle_count(a_cycle), .instr_count(a_instr)
  );

  proc_sequencer #(.CLEAR_CYCLES(3), .MAX_CYCLES(16'd10)) u_dut_b (
    .CLK(clk), .reset(reset), .start(start), .halt_in(halt_in),
    .stall_in(stall_in), .ack(ack),
    .state_ctrl(b_state_ctrl), .reset_ctrl(b_reset_ctrl), .busy(b_busy),
    .done(b_done), .fault(b_fault), .cycle_count(b_cycle), .instr_count(b_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then stable for sampling and inputs
  // may be changed for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_ctrl", 32'(a_state_ctrl), 32'h1);
    check("rst_rc",   32'(a_reset_ctrl), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_flags", 32'({a_done, a_fault}), 32'h0);
    check("rst_cnts", {a_cycle, a_instr}, 32'h0);

    // basic run: CLEAR 1 cycle, halt on 6th RUN cycle
    start = 1'b1; tick(); start = 1'b0;
    check("clr_rc",   32'(a_reset_ctrl), 32'h1);
    check("clr_ctrl", 32'(a_state_ctrl), 32'h1);
    check("clr_busy", 32'(a_busy), 32'h1);
    tick();
    check("run1_rc", 32'(a_reset_ctrl), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      check("run_ctrl", 32'(a_state_ctrl), 32'h0);
      tick();
    end
    check("run6_ctrl", 32'(a_state_ctrl), 32'h0);
    halt_in = 1'b1; tick(); halt_in = 1'b0;
    check("done",      32'(a_done), 32'h1);
    check("done_ctrl", 32'(a_state_ctrl), 32'h2);
    check("done_busy", 32'(a_busy), 32'h0);
    check("done_cyc",  32'(a_cycle), 32'd6);
    check("done_ins",  32'(a_instr), 32'd5);

    // ack alone: back to IDLE, counters retained
    ack = 1'b1; tick(); ack = 1'b0;
    check("ack_done", 32'(a_done), 32'h0);
    check("ack_ctrl", 32'(a_state_ctrl), 32'h1);
    check("ack_cnts", {a_cycle, a_instr}, {16'd6, 16'd5});

    // stall: RUN1,RUN2,RUN3(stall) ST4 ST5(halt ignored) ST6 RUN7 RUN8 RUN9(halt)
    start = 1'b1; tick(); start = 1'b0;
    tick();                                   // RUN1
    tick();                                   // RUN2
    tick();                                   // RUN3
    check("run3_ctrl", 32'(a_state_ctrl), 32'h0);
    stall_in = 1'b1; tick();                  // ST4
    check("st4_ctrl", 32'(a_state_ctrl), 32'h1);
    check("st4_busy", 32'(a_busy), 32'h1);
    halt_in = 1'b1; tick(); halt_in = 1'b0;   // ST5, halt sampled in ST4 ignored
    check("st5_ctrl", 32'(a_state_ctrl), 32'h1);
    check("st5_done", 32'(a_done), 32'h0);
    tick();                                   // ST6
    stall_in = 1'b0;
    check("st6_ctrl", 32'(a_state_ctrl), 32'h1);
    check("st6_cnts", {a_cycle, a_instr}, {16'd5, 16'd2});
    tick();                                   // RUN7
    check("run7_ctrl", 32'(a_state_ctrl), 32'h0);
    tick();                                   // RUN8
    tick();                                   // RUN9
    halt_in = 1'b1; tick(); halt_in = 1'b0;
    check("st_done", 32'(a_done), 32'h1);
    check("st_cnts", {a_cycle, a_instr}, {16'd9, 16'd4});

    // start+ack together in DONE: restart wins
    start = 1'b1; ack = 1'b1; tick(); start = 1'b0; ack = 1'b0;
    check("rs_rc",   32'(a_reset_ctrl), 32'h1);
    check("rs_done", 32'(a_done), 32'h0);
    check("rs_cnts", {a_cycle, a_instr}, 32'h0);
    tick();                                   // RUN1
    halt_in = 1'b1; stall_in = 1'b1; tick(); halt_in = 1'b0; stall_in = 1'b0;
    check("pri_done", 32'(a_done), 32'h1);
    check("pri_ctrl", 32'(a_state_ctrl), 32'h2);
    check("pri_cnts", {a_cycle, a_instr}, {16'd1, 16'd0});

    // reset while in STALL
    ack = 1'b1; tick(); ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();                                   // RUN1
    tick();                                   // RUN2
    stall_in = 1'b1; tick();                  // STALL
    check("mr_pre", 32'(a_state_ctrl), 32'h1);
    check("mr_pre_cnt", {a_cycle, a_instr}, {16'd2, 16'd1});
    reset = 1'b1; tick(); reset = 1'b0; stall_in = 1'b0;
    check("mr_ctrl", 32'(a_state_ctrl), 32'h1);
    check("mr_busy", 32'(a_busy), 32'h0);
    check("mr_flags", 32'({a_done, a_fault}), 32'h0);
    check("mr_cnts", {a_cycle, a_instr}, 32'h0);

    // CLEAR_CYCLES=3 and watchdog at MAX_CYCLES=10 on instance b
    start = 1'b1; tick(); start = 1'b0;
    check("b_clr1", 32'({b_reset_ctrl, b_state_ctrl}), 32'h5);
    tick();
    check("b_clr2", 32'({b_reset_ctrl, b_state_ctrl}), 32'h5);
    tick();
    check("b_clr3", 32'({b_reset_ctrl, b_state_ctrl}), 32'h5);
    tick();
    check("b_run1", 32'({b_reset_ctrl, b_state_ctrl}), 32'h0);
    // RUN1 RUN2 RUN3(st) ST4 RUN5 RUN6(st) ST7 RUN8 RUN9(st) ST10 -> FAULT
    for (int k = 1; k <= 9; k++) begin
      stall_in = (k % 3 == 0);
      tick();
    end
    stall_in = 1'b0;
    check("b_pre_cyc",   32'(b_cycle), 32'd9);
    check("b_pre_fault", 32'(b_fault), 32'h0);
    check("b_pre_ctrl",  32'(b_state_ctrl), 32'h1);
    tick();
    check("b_fault", 32'(b_fault), 32'h1);
    check("b_done",  32'(b_done), 32'h0);
    check("b_ctrl",  32'(b_state_ctrl), 32'h2);
    check("b_cnts",  {b_cycle, b_instr}, {16'd10, 16'd4});
    tick();
    check("b_hold", {b_cycle, b_instr}, {16'd10, 16'd4});
    ack = 1'b1; tick(); ack = 1'b0;
    check("b_ack_fault", 32'(b_fault), 32'h0);
    check("b_ack_cnts", {b_cycle, b_instr}, {16'd10, 16'd4});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
